// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every {a,b,c} input combination into a
// 3-input function, holds each vector SETTLE cycles, and captures f into an
// 8-bit truth table (bit i = f for {a,b,c} = i).
// `table` is a reserved word, so the captured table port is named ttable.
// Optional feature: define SWEEP_COMPARE_EN to add the expected/match
// comparator against a reference table.
module truth_table_sweeper #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       f,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] ttable
`ifdef SWEEP_COMPARE_EN
   ,
   input  logic [7:0] expected,
   output logic       match
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [2:0] idx;
   logic [3:0] cnt;
   logic       settled;
   logic [7:0] cap;

   assign settled = (cnt == CNT_LAST);

   // State register; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: start only matters in IDLE, DONE always falls back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (settled && idx == 3'd7) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Table as it will look after the current vector is captured; the
   // comparator uses this so the last bit counts on the RUN->DONE edge.
   always_comb begin
      cap      = ttable;
      cap[idx] = f;
   end

   // Vector index, settle counter and table capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx    <= '0;
         cnt    <= '0;
         ttable <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx    <= '0;
               cnt    <= '0;
               ttable <= '0;
            end
            RUN: if (settled) begin
               ttable <= cap;
               cnt    <= '0;
               if (idx != 3'd7) idx <= idx + 3'd1;
            end else begin
               cnt <= cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef SWEEP_COMPARE_EN
   // Compare result: loaded on the final capture, cleared by the next start.
   always_ff @(posedge clk) begin
      if (reset)
         match <= 1'b0;
      else if (state == IDLE && start)
         match <= 1'b0;
      else if (state == RUN && settled && idx == 3'd7)
         match <= (cap == expected);
   end
`endif

   // Outputs decoded from registered state only; f never reaches them.
   assign {a, b, c} = (state == RUN) ? idx : 3'b000;
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 2, cycles each input vector is held before f is sampled (legal range 1..15).
REQ-002 The block SHALL have the ports below:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- f  input  1  output of the 3-input function under test.
- a  output  1  function input, MSB of vector index.
- b  output  1  function input, middle bit of vector index.
- c  output  1  function input, LSB of vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table  output  8  captured truth table; bit i = f for {a,b,c} = i.
- expected  input  8  reference table; present only with SWEEP_COMPARE_EN.
- match  output  1  compare result; present only with SWEEP_COMPARE_EN.

Function
REQ-003 The block SHALL implement the three-state FSM IDLE, RUN, DONE, with a 3-bit vector index idx and a settle counter cnt.
REQ-004 In IDLE, when start=1 at a clock edge, the block SHALL enter RUN at that edge, set idx=0 and cnt=0, and clear table to 0x00.
REQ-005 In RUN, {a,b,c} SHALL equal idx, with a as the MSB; in IDLE and DONE, {a,b,c} SHALL be 000.
REQ-006 At each RUN edge where cnt<SETTLE-1, the block SHALL increment cnt.
REQ-007 At each RUN edge where cnt=SETTLE-1, the block SHALL:
- write table[idx]<=f;
- clear cnt;
- increment idx if idx<7, otherwise go to DONE.
REQ-008 RUN SHALL last exactly 8*SETTLE cycles.
REQ-009 When the start edge is edge 0, done SHALL be high in cycle 8*SETTLE+1 only, e.g. cycle 17 for SETTLE=2.
REQ-010 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-011 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-012 start SHALL be ignored in RUN and DONE.
REQ-013 If start is held high continuously, a new sweep SHALL begin at the first IDLE edge, so successive done pulses are 8*SETTLE+2 cycles apart.
REQ-014 table SHALL hold its last captured value in IDLE and DONE until the next accepted start.
REQ-015 All outputs SHALL be registered or decoded from registered state only; f SHALL reach no output combinationally.

Reset
REQ-016 When reset=1 at a clock edge, the block SHALL force:
- state=IDLE, idx=0, cnt=0;
- table=0x00, busy=0, done=0, {a,b,c}=000, match=0.
REQ-017 reset SHALL take priority over start and over all FSM activity.
REQ-018 A reset during RUN SHALL abort the sweep with no done pulse; the next sweep SHALL need a fresh start seen in IDLE.

Configuration
REQ-019 With macro SWEEP_COMPARE_EN defined:
- the ports expected and match SHALL exist;
- on the RUN->DONE edge, match SHALL load (final table == expected), where the final table includes the last bit captured on that same edge;
- match SHALL hold until the next accepted start, which SHALL clear it to 0.
REQ-020 With SWEEP_COMPARE_EN undefined, expected, match and the comparator SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- SETTLE=2, f = a^b^c, start pulsed at edge 0 -> busy=1 in cycles 1-16, done=1 in cycle 17 only, table=0x96.
- SETTLE=1, same f -> done=1 in cycle 9 only, table=0x96; f tied 1 -> table=0xFF; f tied 0 -> table=0x00.
- start held high, SETTLE=2 -> done pulses 18 cycles apart; {a,b,c} follows 000,000,001,001,...,111,111 in each sweep.
- reset=1 at cycle 9 of a SETTLE=2 sweep -> next cycle busy=0, table=0x00, {a,b,c}=000, no done pulse.
- start pulsed during RUN and during DONE -> no effect on the sequence or timing.
- SWEEP_COMPARE_EN, f = a^b^c -> expected=0x96 gives match=1 with done; expected=0x69 gives match=0; match=0 after the next start.
